// File: rtl/vga_pkg.sv
// Shared VGA timing defaults and coordinate/colour types for the sync generator.
package vga_pkg;

    localparam int unsigned DEF_CLK_DIV   = 4;
    localparam int unsigned DEF_H_DISPLAY = 640;
    localparam int unsigned DEF_H_FP      = 16;
    localparam int unsigned DEF_H_SYNC    = 96;
    localparam int unsigned DEF_H_BP      = 48;
    localparam int unsigned DEF_V_DISPLAY = 480;
    localparam int unsigned DEF_V_FP      = 10;
    localparam int unsigned DEF_V_SYNC    = 2;
    localparam int unsigned DEF_V_BP      = 33;

    typedef logic [11:0] rgb_t;
    typedef logic [10:0] coord_t;

    // Inclusive unsigned window test used by the sync decodes.
    function automatic logic in_range(input coord_t v, input coord_t lo, input coord_t hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/pixel_tick_gen.sv
// Mod-CLK_DIV counter; tick is high on the last count, giving a one-clock pixel enable.
module pixel_tick_gen #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset_n,
    output logic tick
);

    localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] r_div;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_div <= '0;
        end else if (r_div == CNT_LAST) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + CNT_W'(1);
        end
    end

    assign tick = (r_div == CNT_LAST);

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing, sync decode and blanked colour output stage.
// Optional macro VGA_SYNC_ALIGN_EN registers hsync/vsync/video_on by one pixel to line up with rgb_out.
module vga_sync_gen
    import vga_pkg::*;
#(
    parameter int unsigned CLK_DIV   = DEF_CLK_DIV,
    parameter int unsigned H_DISPLAY = DEF_H_DISPLAY,
    parameter int unsigned H_FP      = DEF_H_FP,
    parameter int unsigned H_SYNC    = DEF_H_SYNC,
    parameter int unsigned H_BP      = DEF_H_BP,
    parameter int unsigned V_DISPLAY = DEF_V_DISPLAY,
    parameter int unsigned V_FP      = DEF_V_FP,
    parameter int unsigned V_SYNC    = DEF_V_SYNC,
    parameter int unsigned V_BP      = DEF_V_BP
) (
    input  logic   clk,
    input  logic   reset_n,
    input  rgb_t   rgb_in,
    output coord_t x,
    output coord_t y,
    output logic   p_tick,
    output logic   video_on,
    output logic   hsync,
    output logic   vsync,
    output logic   frame_start,
    output rgb_t   rgb_out
);

    localparam int unsigned H_TOTAL = H_DISPLAY + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_DISPLAY + V_FP + V_SYNC + V_BP;

    localparam coord_t H_LAST   = coord_t'(H_TOTAL - 1);
    localparam coord_t V_LAST   = coord_t'(V_TOTAL - 1);
    localparam coord_t H_VIS    = coord_t'(H_DISPLAY);
    localparam coord_t V_VIS    = coord_t'(V_DISPLAY);
    localparam coord_t HS_START = coord_t'(H_DISPLAY + H_FP);
    localparam coord_t HS_END   = coord_t'(H_DISPLAY + H_FP + H_SYNC - 1);
    localparam coord_t VS_START = coord_t'(V_DISPLAY + V_FP);
    localparam coord_t VS_END   = coord_t'(V_DISPLAY + V_FP + V_SYNC - 1);

    logic   w_tick;
    logic   w_x_wrap;
    logic   w_y_wrap;
    logic   w_video_on;
    logic   w_hsync;
    logic   w_vsync;
    coord_t r_x;
    coord_t r_y;
    rgb_t   r_rgb;

    pixel_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_pixel_tick_gen (
        .clk     (clk),
        .reset_n (reset_n),
        .tick    (w_tick)
    );

    assign w_x_wrap = (r_x == H_LAST);
    assign w_y_wrap = (r_y == V_LAST);

    // y only moves on the pixel where x wraps, so both wrap together at frame end.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_x <= '0;
            r_y <= '0;
        end else if (w_tick) begin
            if (w_x_wrap) begin
                r_x <= '0;
                r_y <= w_y_wrap ? '0 : r_y + 11'd1;
            end else begin
                r_x <= r_x + 11'd1;
            end
        end
    end

    assign w_video_on = (r_x < H_VIS) && (r_y < V_VIS);
    assign w_hsync    = !in_range(r_x, HS_START, HS_END);
    assign w_vsync    = !in_range(r_y, VS_START, VS_END);

    // Blanking uses the undelayed decode so the sampled colour matches the pixel it belongs to.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_rgb <= '0;
        end else if (w_tick) begin
            r_rgb <= w_video_on ? rgb_in : rgb_t'(0);
        end
    end

`ifdef VGA_SYNC_ALIGN_EN
    logic r_hsync;
    logic r_vsync;
    logic r_video_on;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_hsync    <= 1'b1;
            r_vsync    <= 1'b1;
            r_video_on <= 1'b0;
        end else if (w_tick) begin
            r_hsync    <= w_hsync;
            r_vsync    <= w_vsync;
            r_video_on <= w_video_on;
        end
    end

    assign hsync    = r_hsync;
    assign vsync    = r_vsync;
    assign video_on = r_video_on;
`else
    assign hsync    = w_hsync;
    assign vsync    = w_vsync;
    assign video_on = w_video_on;
`endif

    assign x           = r_x;
    assign y           = r_y;
    assign p_tick      = w_tick;
    assign frame_start = w_tick && w_x_wrap && w_y_wrap;
    assign rgb_out     = r_rgb;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Scoreboard bench: default-timing instance plus a shrunken-timing instance checked against an arithmetic raster model.
module tb_vga_sync_gen;

    typedef struct packed {
        logic [10:0] x;
        logic [10:0] y;
        logic        p_tick;
        logic        video_on;
        logic        hsync;
        logic        vsync;
        logic        frame_start;
        logic [11:0] rgb;
    } obs_t;

    typedef struct {
        int cd;
        int hd, hfp, hs, hbp;
        int vd, vfp, vs, vbp;
    } tcfg_t;

    typedef struct {
        obs_t d;
        obs_t s;
        int   t;
        bit   seg1;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [11:0] rgb_in;

    logic [10:0] x_d, y_d, x_s, y_s;
    logic        pt_d, vo_d, hs_d, vs_d, fs_d;
    logic        pt_s, vo_s, hs_s, vs_s, fs_s;
    logic [11:0] rgb_d, rgb_s;

    tcfg_t cfg_d;
    tcfg_t cfg_s;

    exp_t q[$];

    int  n_checks = 0;
    int  n_pass   = 0;
    int  hs_low_line0 = 0;
    int  fs_first_frame = 0;
    int  fs_first_t = -1;
    int  first_tick_t = -1;
    bit  seg1 = 1'b0;

    always #5 clk = ~clk;

    vga_sync_gen dut_d (
        .clk         (clk),
        .reset_n     (reset_n),
        .rgb_in      (rgb_in),
        .x           (x_d),
        .y           (y_d),
        .p_tick      (pt_d),
        .video_on    (vo_d),
        .hsync       (hs_d),
        .vsync       (vs_d),
        .frame_start (fs_d),
        .rgb_out     (rgb_d)
    );

    vga_sync_gen #(
        .CLK_DIV (3),
        .H_DISPLAY (8), .H_FP (2), .H_SYNC (3), .H_BP (2),
        .V_DISPLAY (6), .V_FP (1), .V_SYNC (2), .V_BP (2)
    ) dut_s (
        .clk         (clk),
        .reset_n     (reset_n),
        .rgb_in      (rgb_in),
        .x           (x_s),
        .y           (y_s),
        .p_tick      (pt_s),
        .video_on    (vo_s),
        .hsync       (hs_s),
        .vsync       (vs_s),
        .frame_start (fs_s),
        .rgb_out     (rgb_s)
    );

    function automatic int htot(input tcfg_t c);
        return c.hd + c.hfp + c.hs + c.hbp;
    endfunction

    function automatic int vtot(input tcfg_t c);
        return c.vd + c.vfp + c.vs + c.vbp;
    endfunction

    function automatic bit visible(input tcfg_t c, input int n);
        int px;
        int py;
        px = n % htot(c);
        py = (n / htot(c)) % vtot(c);
        return (px < c.hd) && (py < c.vd);
    endfunction

    // Expected outputs t clocks after reset release, given the last colour sampled.
    function automatic obs_t model(input tcfg_t c, input int t, input logic [11:0] last);
        obs_t o;
        int n, px, py, dx, dy;
        n  = t / c.cd;
        px = n % htot(c);
        py = (n / htot(c)) % vtot(c);
        o.x           = 11'(px);
        o.y           = 11'(py);
        o.p_tick      = ((t % c.cd) == c.cd - 1);
        o.frame_start = o.p_tick && (px == htot(c) - 1) && (py == vtot(c) - 1);
        o.rgb         = last;
`ifdef VGA_SYNC_ALIGN_EN
        if (n == 0) begin
            o.hsync = 1'b1;
            o.vsync = 1'b1;
            o.video_on = 1'b0;
            return o;
        end
        n = n - 1;
`endif
        dx = n % htot(c);
        dy = (n / htot(c)) % vtot(c);
        o.hsync    = !((dx >= c.hd + c.hfp) && (dx < c.hd + c.hfp + c.hs));
        o.vsync    = !((dy >= c.vd + c.vfp) && (dy < c.vd + c.vfp + c.vs));
        o.video_on = (dx < c.hd) && (dy < c.vd);
        return o;
    endfunction

    task automatic chk(input string name, input int t, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s t=%0d actual=%h required=%h", name, t, act, req);
    endtask

    // Stimulus and model state.
    int          t = 0;
    logic [11:0] last_d = '0;
    logic [11:0] last_s = '0;

    task automatic step(input logic rst_v, input logic [11:0] rgb_v);
        exp_t e;
        reset_n = rst_v;
        rgb_in  = rgb_v;
        if (!rst_v) begin
            t = 0;
            last_d = '0;
            last_s = '0;
        end else begin
            if ((t % cfg_d.cd) == cfg_d.cd - 1)
                last_d = visible(cfg_d, t / cfg_d.cd) ? rgb_v : 12'h000;
            if ((t % cfg_s.cd) == cfg_s.cd - 1)
                last_s = visible(cfg_s, t / cfg_s.cd) ? rgb_v : 12'h000;
            t++;
        end
        e.d = model(cfg_d, t, last_d);
        e.s = model(cfg_s, t, last_s);
        e.t = t;
        e.seg1 = seg1;
        @(posedge clk);
        #1;
        q.push_back(e);
    endtask

    // Monitor: every clock is an output beat; compare mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        obs_t a_d;
        obs_t a_s;
        if (q.size() != 0) begin
            e   = q.pop_front();
            a_d = {x_d, y_d, pt_d, vo_d, hs_d, vs_d, fs_d, rgb_d};
            a_s = {x_s, y_s, pt_s, vo_s, hs_s, vs_s, fs_s, rgb_s};
            chk("raster_default", e.t, 64'(a_d), 64'(e.d));
            chk("raster_small", e.t, 64'(a_s), 64'(e.s));
            if (e.seg1) begin
                if (e.t < 3200 && hs_d === 1'b0) hs_low_line0++;
                if (e.t < 495 && fs_s === 1'b1) begin
                    fs_first_frame++;
                    if (fs_first_t < 0) fs_first_t = e.t;
                end
                if (first_tick_t < 0 && pt_d === 1'b1) first_tick_t = e.t;
            end
        end
    end

    initial begin
        cfg_d = '{4, 640, 16, 96, 48, 480, 10, 2, 33};
        cfg_s = '{3, 8, 2, 3, 2, 6, 1, 2, 2};
        reset_n = 1'b0;
        rgb_in  = 12'h000;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) step(1'b0, 12'(($urandom)));

        // First lines with a constant colour, then random colour.
        seg1 = 1'b1;
        for (int i = 0; i < 3300; i++) step(1'b1, 12'hF0F);
        for (int i = 0; i < 6700; i++) step(1'b1, 12'($urandom));
        seg1 = 1'b0;

        // Mid-frame reset, then random traffic with occasional resets.
        step(1'b0, 12'($urandom));
        for (int i = 0; i < 2500; i++)
            step(($urandom_range(0, 799) != 0), 12'($urandom));

        @(negedge clk);
        @(negedge clk);
        chk("queue_drained", 0, 64'(q.size()), 64'd0);
        chk("first_ptick_clock", 0, 64'(first_tick_t), 64'd3);
        chk("hsync_low_clocks_line0", 0, 64'(hs_low_line0), 64'd384);
        chk("frame_start_count_frame0", 0, 64'(fs_first_frame), 64'd1);
        chk("frame_start_clock_frame0", 0, 64'(fs_first_t), 64'd494);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

Generates 640x480@60 Hz VGA timing from the 100 MHz system clock. Provides the pixel coordinates `x`, `y` consumed by the square pattern generator, the active-low `hsync`/`vsync` for the connector, and a registered 12-bit RGB output stage that blanks the pattern generator's colour outside the visible area. Sits directly upstream of the pattern generator (coordinates) and directly downstream of it (colour back-end).

## Interface
- `CLK_DIV`, 4: system clocks per pixel (100 MHz / 4 = 25 MHz pixel rate).
- `H_DISPLAY`, 640; `H_FP`, 16; `H_SYNC`, 96; `H_BP`, 48: horizontal timing in pixels.
- `V_DISPLAY`, 480; `V_FP`, 10; `V_SYNC`, 2; `V_BP`, 33: vertical timing in lines.

Ports:
- `clk` in 1: system clock, 100 MHz.
- `reset_n` in 1: reset, synchronous, active-low.
- `rgb_in` in 12: colour from the pattern generator for the current `x`, `y`.
- `x` out 11: horizontal counter, 0..H_TOTAL-1.
- `y` out 11: vertical counter, 0..V_TOTAL-1.
- `p_tick` out 1: one-clock pixel-enable strobe.
- `video_on` out 1: high when `x < H_DISPLAY` and `y < V_DISPLAY`.
- `hsync` out 1: horizontal sync, active-low.
- `vsync` out 1: vertical sync, active-low.
- `frame_start` out 1: one-clock pulse on the last pixel of the frame.
- `rgb_out` out 12: registered, blanked colour to the DAC/connector.

## Operation
- Derived constants: H_TOTAL = 800 and V_TOTAL = 525, each the sum of its four timing parameters.
- Divider `div` counts 0..CLK_DIV-1 every `clk`, then wraps. `p_tick` = (`div` == CLK_DIV-1), combinational.
- `x` advances on every `clk` edge where `p_tick` = 1. It wraps from H_TOTAL-1 (799) to 0.
- `y` advances only when `x` wraps. It wraps from V_TOTAL-1 (524) to 0.
- `x` and `y` hold between ticks.
- `hsync` = 0 for `x` in [H_DISPLAY+H_FP, H_DISPLAY+H_FP+H_SYNC-1] = [656, 751]; otherwise 1.
- `vsync` = 0 for `y` in [490, 491]; otherwise 1.
- `frame_start` = `p_tick` AND `x` == 799 AND `y` == 524.
- `rgb_out` updates only on `p_tick`: it takes `rgb_in` when `video_on` = 1, else 12'h000. It holds between ticks.
- Arithmetic: all comparisons are unsigned 11-bit. Parameters must give H_TOTAL and V_TOTAL ≤ 2047.

## Timing
- Reset values (reset asserted at a `clk` edge): `div` = 0, `x` = 0, `y` = 0, `rgb_out` = 0, `p_tick` = 0, `frame_start` = 0.
- In the default build, `hsync` = 1, `vsync` = 1 and `video_on` = 1 during reset, because these decode the reset counters.
- First `p_tick` occurs CLK_DIV-1 clocks after reset is released. `x` becomes 1 on the clock edge that samples it.
- Reset mid-frame: all counters return to 0 at the next edge. No partial-line completion.
- Pattern-generator latency budget: `rgb_in` must be valid within one pixel period (CLK_DIV clocks) of the `x`/`y` change. It is sampled on the next `p_tick`.
- Consequently `rgb_out` lags `x`/`y` by one pixel.
- Simultaneous wraps: at `x` = 799, `y` = 524 with `p_tick`, both counters go to 0 on the same edge, and `frame_start` is high for that one clock.
- Line period: 800 × CLK_DIV clocks. Frame period: 525 × 800 × CLK_DIV = 1 680 000 clocks.

## Configuration
- `VGA_SYNC_ALIGN_EN` defined:
  - `hsync`, `vsync` and `video_on` are registered on `p_tick` from their decodes, giving a one-pixel delay that aligns them with `rgb_out`.
  - Reset values: `hsync` = 1, `vsync` = 1, `video_on` = 0.
  - The blanking decision for `rgb_out` still uses the undelayed decode.
- Not defined: `hsync`, `vsync` and `video_on` are combinational decodes of `x`/`y`. They lead `rgb_out` by one pixel.

## Structure
- Package `vga_pkg` holds:
  - default timing localparams (640/16/96/48, 480/10/2/33);
  - `typedef logic [11:0] rgb_t`;
  - `typedef logic [10:0] coord_t`.
- Sub-module `pixel_tick_gen`: a mod-CLK_DIV counter with ports `clk`, `reset_n`, `tick`. It is instantiated once.
- All other logic lives in `vga_sync_gen`.

## Test plan
- Reset release, no stimulus: `p_tick` first high at clock 3 after release. `x` = 1 at clock 4. `y` = 0. `rgb_out` = 0.
- Run one line: `hsync` low for exactly 96 × 4 = 384 clocks, starting when `x` = 656. `x` wraps 799→0 and `y` steps 0→1 on the same edge.
- Run one full frame: `vsync` low while `y` ∈ {490, 491}. `frame_start` is high exactly once, 1 680 000 clocks after release minus 1, with `x` = 799 and `y` = 524.
- Blanking: `rgb_in` = 12'hF0F held constant. `rgb_out` = F0F for `x` 1..640 of visible lines, 000 at `x` = 641..800, and 000 for all of `y` ≥ 480.
- Reset mid-frame at `y` = 200, `x` = 300: one edge later `x` = 0, `y` = 0, `rgb_out` = 0, and the divider restarts at 0.
- With `VGA_SYNC_ALIGN_EN`: the `hsync` falling edge occurs one pixel (4 clocks) after `x` reaches 656, coincident with `rgb_out` for pixel 656. `video_on` = 0 during reset.
